load_store_unit: RTL and testbench

Sits between the single-cycle RV64I datapath and the data memory bus. It takes the ALU address, store data and funct3 for the current load or store, and drives one aligned 64-bit bus transaction with a req/ack handshake. It formats byte lanes for stores and extracts and extends the loaded value. While a transaction is in flight it asserts stall, which holds pc_write_en and regfile_write_en low.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_store_unit_align.sv | 56 +++++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding, lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  // Offset bits that survive natural alignment for the access size in funct3[1:0].
  function automatic logic [2:0] align_mask(input logic [2:0] f3);
    logic [2:0] m;
    case (f3[1:0])
      2'b00:   m = 3'b111;
      2'b01:   m = 3'b110;
      2'b10:   m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // True when the offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    return (off & ~align_mask(f3)) != 3'b000;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane formatting: store replication/byte enables and load shift/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [2:0]  st_off_i,
  input  logic [63:0] st_data_i,
  output logic [63:0] st_wdata_o,
  output logic [7:0]  st_byte_en_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [2:0]  ld_off_i,
  input  logic [63:0] ld_rdata_i,
  output logic [63:0] ld_value_o
);

  logic [63:0] ld_shifted;

  // Replicate store data across lanes and select the lanes being written.
  always_comb begin
    st_wdata_o   = st_data_i;
    st_byte_en_o = BE_D;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_wdata_o   = {8{st_data_i[7:0]}};
        st_byte_en_o = BE_B << st_off_i;
      end
      2'b01: begin
        st_wdata_o   = {4{st_data_i[15:0]}};
        st_byte_en_o = BE_H << st_off_i;
      end
      2'b10: begin
        st_wdata_o   = {2{st_data_i[31:0]}};
        st_byte_en_o = BE_W << st_off_i;
      end
      default: begin
        st_wdata_o   = st_data_i;
        st_byte_en_o = BE_D;
      end
    endcase
  end

  // Move the addressed bytes down to bit 0, then truncate and extend.
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_B:    ld_value_o = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      F3_H:    ld_value_o = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_W:    ld_value_o = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      F3_BU:   ld_value_o = {56'd0, ld_shifted[7:0]};
      F3_HU:   ld_value_o = {48'd0, ld_shifted[15:0]};
      F3_WU:   ld_value_o = {32'd0, ld_shifted[31:0]};
      default: ld_value_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned 64-bit bus transaction per load/store with
// req/ack handshake, timeout abort and pipeline stall.
// Optional: define MISALIGNED_TRAP_EN to fault misaligned accesses instead of
// masking the address down to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [2:0]            inst_funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [63:0]           store_data,
  output logic [63:0]           load_data,
  output logic                  stall,
  output logic                  done,
  output logic                  access_fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [7:0]            dmem_byte_en,
  output logic [63:0]           dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [63:0]           dmem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            be_q, be_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [2:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [63:0]           ld_q, ld_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;

  logic        req_any_c;
  logic        misaligned_c;
  logic        illegal_c;
  logic [2:0]  off_c;
  logic [63:0] st_wdata_c;
  logic [7:0]  st_be_c;
  logic [63:0] ld_value_c;

  assign req_any_c = mem_read_en | mem_write_en;
  assign off_c     = address[2:0] & align_mask(inst_funct3);

`ifdef MISALIGNED_TRAP_EN
  assign misaligned_c = is_misaligned(inst_funct3, address[2:0]);
`else
  assign misaligned_c = 1'b0;
`endif

  // Read+write together, load funct3 111, store funct3 1xx, or trapped misalignment.
  assign illegal_c = (mem_read_en & mem_write_en)
                   | (mem_read_en & (inst_funct3 == 3'b111))
                   | (mem_write_en & inst_funct3[2])
                   | misaligned_c;

  lsu_align u_align (
    .st_funct3_i  (inst_funct3),
    .st_off_i     (off_c),
    .st_data_i    (store_data),
    .st_wdata_o   (st_wdata_c),
    .st_byte_en_o (st_be_c),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (dmem_rdata),
    .ld_value_o   (ld_value_c)
  );

  // State and output registers; reset drops the bus request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and next-register values for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    fault_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any_c) begin
          if (illegal_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            ld_d    = '0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = mem_write_en;
            addr_d  = {address[ADDR_WIDTH-1:3], 3'b000};
            be_d    = st_be_c;
            wdata_d = st_wdata_c;
            off_d   = off_c;
            f3_d    = inst_funct3;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          ld_d    = we_q ? 64'd0 : ld_value_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
          ld_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Stall follows the request level in IDLE so the current instruction holds.
  assign stall = ~rst & (((state_q == IDLE) & req_any_c) | (state_q == BUSY));

  assign load_data    = ld_q;
  assign done         = done_q;
  assign access_fault = fault_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_byte_en = be_q;
  assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a result scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  inst_funct3;
  logic [63:0] address, store_data;
  logic [63:0] load_data;
  logic        stall, done, access_fault;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_byte_en;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  typedef struct packed {
    logic [63:0] ld;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .inst_funct3  (inst_funct3),
    .address      (address),
    .store_data   (store_data),
    .load_data    (load_data),
    .stall        (stall),
    .done         (done),
    .access_fault (access_fault),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_byte_en (dmem_byte_en),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one access from a falling edge and follows it until done.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [63:0] rdata,
                        input int waits, input bit never,
                        input logic [63:0] exp_ld, input logic exp_fault,
                        input bit exp_bus, input logic [7:0] exp_be,
                        input logic [63:0] exp_wdata, input int exp_done);
    exp_t e;
    int   cyc;
    int   busy;
    bit   seen_bus;
    bit   fin;
    mem_read_en  = rd;
    mem_write_en = wr;
    inst_funct3  = f3;
    address      = addr;
    store_data   = sdata;
    dmem_rdata   = rdata;
    dmem_ack     = 1'b0;
    e.ld    = exp_ld;
    e.fault = exp_fault;
    sb_q.push_back(e);
    #1;
    chk({name, " stall_c0"}, 64'(stall), 64'd1);
    cyc = 0; busy = 0; seen_bus = 1'b0; fin = 1'b0;
    while (!fin && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      dmem_ack = 1'b0;
      if (done) begin
        fin = 1'b1;
        e = sb_q.pop_front();
        chk({name, " load_data"}, load_data, e.ld);
        chk({name, " fault"}, 64'(access_fault), 64'(e.fault));
        chk({name, " stall_done"}, 64'(stall), 64'd0);
        chk({name, " req_done"}, 64'(dmem_req), 64'd0);
        chk({name, " bus_issued"}, 64'(seen_bus), 64'(exp_bus));
        if (exp_done >= 0) chk({name, " done_cycle"}, 64'(cyc), 64'(exp_done));
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
      end else begin
        chk({name, " stall_busy"}, 64'(stall), 64'd1);
        if (dmem_req) begin
          if (!seen_bus) begin
            seen_bus = 1'b1;
            chk({name, " we"}, 64'(dmem_we), 64'(wr));
            chk({name, " addr"}, dmem_addr, addr & ~64'h7);
            if (wr) begin
              chk({name, " byte_en"}, 64'(dmem_byte_en), 64'(exp_be));
              chk({name, " wdata"}, dmem_wdata, exp_wdata);
            end
          end
          busy++;
          if (!never && busy > waits) dmem_ack = 1'b1;
        end
      end
    end
    if (!fin) begin
      chk({name, " done_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, " done_pulse_end"}, 64'(done), 64'd0);
    chk({name, " stall_idle"}, 64'(stall), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    inst_funct3  = 3'b000;
    address      = '0;
    store_data   = '0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;
    #12;
    chk("reset req", 64'(dmem_req), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset fault", 64'(access_fault), 64'd0);
    chk("reset load_data", load_data, 64'd0);
    chk("reset byte_en", 64'(dmem_byte_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    access("SD", 1'b0, 1'b1, F3_D, 64'h1000, 64'h1122334455667788, 64'h0, 0, 1'b0,
           64'h0, 1'b0, 1'b1, 8'hFF, 64'h1122334455667788, 2);
    access("LB", 1'b1, 1'b0, F3_B, 64'h1003, 64'h0, 64'h0000000080000000, 3, 1'b0,
           64'hFFFFFFFFFFFFFF80, 1'b0, 1'b1, 8'h00, 64'h0, 5);
    access("LBU", 1'b1, 1'b0, F3_BU, 64'h1003, 64'h0, 64'h0000000080000000, 3, 1'b0,
           64'h0000000000000080, 1'b0, 1'b1, 8'h00, 64'h0, 5);
    access("SH", 1'b0, 1'b1, F3_H, 64'h2006, 64'h123400000000ABCD, 64'h0, 0, 1'b0,
           64'h0, 1'b0, 1'b1, 8'hC0, 64'hABCDABCDABCDABCD, 2);
    access("SB", 1'b0, 1'b1, F3_B, 64'h1005, 64'hFFFFFFFFFFFFFF5A, 64'h0, 0, 1'b0,
           64'h0, 1'b0, 1'b1, 8'h20, 64'h5A5A5A5A5A5A5A5A, 2);
    access("SW", 1'b0, 1'b1, F3_W, 64'h1004, 64'h11112222CAFEF00D, 64'h0, 0, 1'b0,
           64'h0, 1'b0, 1'b1, 8'hF0, 64'hCAFEF00DCAFEF00D, 2);
    access("LW", 1'b1, 1'b0, F3_W, 64'h1004, 64'h0, 64'hDEADBEEF00000000, 1, 1'b0,
           64'hFFFFFFFFDEADBEEF, 1'b0, 1'b1, 8'h00, 64'h0, 3);
    access("LWU", 1'b1, 1'b0, F3_WU, 64'h1004, 64'h0, 64'hDEADBEEF00000000, 1, 1'b0,
           64'h00000000DEADBEEF, 1'b0, 1'b1, 8'h00, 64'h0, 3);
    access("LH", 1'b1, 1'b0, F3_H, 64'h1002, 64'h0, 64'h0000000080010000, 0, 1'b0,
           64'hFFFFFFFFFFFF8001, 1'b0, 1'b1, 8'h00, 64'h0, 2);
    access("LHU", 1'b1, 1'b0, F3_HU, 64'h1002, 64'h0, 64'h0000000080010000, 0, 1'b0,
           64'h0000000000008001, 1'b0, 1'b1, 8'h00, 64'h0, 2);
    access("LD", 1'b1, 1'b0, F3_D, 64'h1000, 64'h0, 64'h0123456789ABCDEF, 2, 1'b0,
           64'h0123456789ABCDEF, 1'b0, 1'b1, 8'h00, 64'h0, 4);
`ifdef MISALIGNED_TRAP_EN
    access("SH_misaligned", 1'b0, 1'b1, F3_H, 64'h2007, 64'h000000000000ABCD, 64'h0, 0, 1'b0,
           64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1);
`else
    access("SH_misaligned", 1'b0, 1'b1, F3_H, 64'h2007, 64'h000000000000ABCD, 64'h0, 0, 1'b0,
           64'h0, 1'b0, 1'b1, 8'hC0, 64'hABCDABCDABCDABCD, 2);
`endif
    access("LW_timeout", 1'b1, 1'b0, F3_W, 64'h3000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 1'b1,
           64'h0, 1'b1, 1'b1, 8'h00, 64'h0, -1);
    access("LD_after_timeout", 1'b1, 1'b0, F3_D, 64'h3008, 64'h0, 64'h00000000000000A5, 0, 1'b0,
           64'h00000000000000A5, 1'b0, 1'b1, 8'h00, 64'h0, 2);
    access("load_f3_111", 1'b1, 1'b0, 3'b111, 64'h1000, 64'h0, 64'h0, 0, 1'b0,
           64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1);
    access("read_and_write", 1'b1, 1'b1, F3_D, 64'h1000, 64'h0, 64'h0, 0, 1'b0,
           64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1);
    access("store_f3_100", 1'b0, 1'b1, 3'b100, 64'h1000, 64'h0, 64'h0, 0, 1'b0,
           64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1);

    // Load a nonzero value so reset clearing load_data is observable.
    access("LBU_pre_reset", 1'b1, 1'b0, F3_BU, 64'h1000, 64'h0, 64'h00000000000000C3, 0, 1'b0,
           64'h00000000000000C3, 1'b0, 1'b1, 8'h00, 64'h0, 2);

    // Reset in the middle of BUSY, then a late ack.
    mem_read_en = 1'b1;
    inst_funct3 = F3_D;
    address     = 64'h4000;
    dmem_rdata  = 64'h5555AAAA5555AAAA;
    @(posedge clk);
    @(negedge clk);
    chk("midreset req_before", 64'(dmem_req), 64'd1);
    chk("midreset stall_before", 64'(stall), 64'd1);
    mem_read_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset req", 64'(dmem_req), 64'd0);
    chk("midreset stall", 64'(stall), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset load_data", load_data, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack done", 64'(done), 64'd0);
    chk("late_ack req", 64'(dmem_req), 64'd0);
    chk("late_ack load_data", load_data, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("late_ack done_next", 64'(done), 64'd0);
    chk("late_ack stall", 64'(stall), 64'd0);

    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
